// File: rtl/stack_defs.sv
// Shared stack geometry and operation types for the stack pointer, control unit
// and memory address mux.
package stack_defs;

   localparam int unsigned SP_WIDTH = 10;

   typedef logic [SP_WIDTH-1:0] sp_t;

   localparam sp_t SP_TOP    = 10'h3FF;
   localparam sp_t SP_BOTTOM = 10'h000;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic conflict;
      logic bad_load;
   } sp_err_t;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_LOAD,
      OP_CONFLICT,
      OP_PUSH,
      OP_POP
   } sp_op_e;

   // Resolve simultaneous requests: load > push&pop > push > pop > hold.
   function automatic sp_op_e decode_op(input logic load, input logic push, input logic pop);
      if (load)             return OP_LOAD;
      else if (push && pop) return OP_CONFLICT;
      else if (push)        return OP_PUSH;
      else if (pop)         return OP_POP;
      else                  return OP_HOLD;
   endfunction

endpackage

// File: rtl/stack_pointer_unit_if.sv
// Request/status bundle between the control unit and the stack pointer unit.
interface stack_pointer_unit_if;
   import stack_defs::*;

   logic push;
   logic pop;
   logic load;
   sp_t  load_value;
   sp_t  sp;
   sp_t  push_addr;
   sp_t  pop_addr;
   logic full;
   logic empty;
   logic overflow_err;
   logic underflow_err;
   logic conflict_err;
   logic range_err;

   modport master (
      output push, pop, load, load_value,
      input  sp, push_addr, pop_addr, full, empty,
      input  overflow_err, underflow_err, conflict_err, range_err
   );

   modport slave (
      input  push, pop, load, load_value,
      output sp, push_addr, pop_addr, full, empty,
      output overflow_err, underflow_err, conflict_err, range_err
   );

endinterface

// File: rtl/ten_bit_decrementer.sv
// 10-bit decrement by one; o flags the borrow out of a == 0.
module ten_bit_decrementer
   import stack_defs::*;
(
   input  sp_t  a,
   output sp_t  s,
   output logic o
);

   assign {o, s} = {1'b0, a} - 11'd1;

endmodule

// File: rtl/ten_bit_incrementer.sv
// 10-bit increment by one; o flags the carry out of a == 10'h3FF.
module ten_bit_incrementer
   import stack_defs::*;
(
   input  sp_t  a,
   output sp_t  s,
   output logic o
);

   assign {o, s} = {1'b0, a} + 11'd1;

endmodule

// File: rtl/stack_pointer_unit.sv
// Registered pointer for the downward-growing hardware stack, with full/empty
// tracking, zero-latency memory addresses and sticky error flags.
module stack_pointer_unit
   import stack_defs::*;
#(
   parameter sp_t TOP    = SP_TOP,
   parameter sp_t BOTTOM = SP_BOTTOM
) (
   input logic clk,
   input logic rst,
   stack_pointer_unit_if.slave bus
);

   sp_t     sp_q, sp_d;
   logic    full_q, full_d;
   sp_err_t err_q, err_d;

   sp_t     dec_s, inc_s;
   logic    dec_o, inc_o;
   logic    at_bottom;
   logic    empty_c;
   logic    load_ok;
   sp_op_e  op;

   logic [SP_WIDTH:0] lo_diff, hi_diff;

   ten_bit_decrementer u_dec (.a(sp_q), .s(dec_s), .o(dec_o));
   ten_bit_incrementer u_inc (.a(sp_q), .s(inc_s), .o(inc_o));

   // Range check via borrow bits so a bound at 0 or 3FF never folds to a constant compare.
   assign lo_diff = {1'b0, bus.load_value} - {1'b0, BOTTOM};
   assign hi_diff = {1'b0, TOP} - {1'b0, bus.load_value};
   assign load_ok = !lo_diff[SP_WIDTH] && !hi_diff[SP_WIDTH];

   assign op        = decode_op(bus.load, bus.push, bus.pop);
   assign at_bottom = (sp_q == BOTTOM);
   assign empty_c   = (sp_q == TOP) && !full_q;

   assign bus.sp            = sp_q;
   assign bus.push_addr     = sp_q;
   assign bus.pop_addr      = full_q ? sp_q : inc_s;
   assign bus.full          = full_q;
   assign bus.empty         = empty_c;
   assign bus.overflow_err  = err_q.overflow;
   assign bus.underflow_err = err_q.underflow;
   assign bus.conflict_err  = err_q.conflict;
   assign bus.range_err     = err_q.bad_load;

   // Next pointer/flag state for the resolved request.
   always_comb begin
      sp_d   = sp_q;
      full_d = full_q;
      err_d  = err_q;
      unique case (op)
         OP_LOAD: begin
            if (load_ok) begin
               sp_d   = bus.load_value;
               full_d = 1'b0;
            end else begin
               err_d.bad_load = 1'b1;
            end
         end
         OP_CONFLICT: err_d.conflict = 1'b1;
         OP_PUSH: begin
            if (full_q)         err_d.overflow = 1'b1;
            else if (at_bottom) full_d = 1'b1;
            else                sp_d = dec_s;
         end
         OP_POP: begin
            if (empty_c)     err_d.underflow = 1'b1;
            else if (full_q) full_d = 1'b0;
            else             sp_d = inc_s;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q   <= TOP;
         full_q <= 1'b0;
         err_q  <= '0;
      end else begin
         sp_q   <= sp_d;
         full_q <= full_d;
         err_q  <= err_d;
      end
   end

   // The pointer is kept inside [BOTTOM, TOP], so neither unit may carry out on a real step.
   always_ff @(posedge clk) begin
      if (!rst && op == OP_PUSH && !full_q && !at_bottom) assert (!dec_o);
      if (!rst && op == OP_POP && !empty_c && !full_q)    assert (!inc_o);
   end

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed bench for stack_pointer_unit: default geometry plus a BOTTOM=10'h100 instance.
module tb_stack_pointer_unit;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   stack_pointer_unit_if bus0 ();
   stack_pointer_unit_if bus1 ();

   stack_pointer_unit dut0 (.clk(clk), .rst(rst), .bus(bus0));
   stack_pointer_unit #(.TOP(10'h3FF), .BOTTOM(10'h100)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive0(input logic ld, input logic ps, input logic pp, input logic [9:0] lv);
      bus0.load = ld; bus0.push = ps; bus0.pop = pp; bus0.load_value = lv;
      #1;
   endtask

   task automatic drive1(input logic ld, input logic ps, input logic pp, input logic [9:0] lv);
      bus1.load = ld; bus1.push = ps; bus1.pop = pp; bus1.load_value = lv;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive0(1'b0, 1'b0, 1'b0, 10'h000);
      drive1(1'b0, 1'b0, 1'b0, 10'h000);
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [3:0] errs0();
      return {bus0.overflow_err, bus0.underflow_err, bus0.conflict_err, bus0.range_err};
   endfunction

   function automatic logic [3:0] errs1();
      return {bus1.overflow_err, bus1.underflow_err, bus1.conflict_err, bus1.range_err};
   endfunction

   task automatic test_reset();
      do_reset();
      tick(); tick();
      tests_run++;
      if (bus0.sp !== 10'h3FF) begin tests_failed++; $display("FAIL reset_sp: got %h expected 3ff", bus0.sp); end
      tests_run++;
      if ({bus0.empty, bus0.full} !== 2'b10) begin tests_failed++; $display("FAIL reset_empty_full: got %b expected 10", {bus0.empty, bus0.full}); end
      tests_run++;
      if (errs0() !== 4'b0000) begin tests_failed++; $display("FAIL reset_errs: got %b expected 0000", errs0()); end
      tests_run++;
      if (bus0.push_addr !== 10'h3FF) begin tests_failed++; $display("FAIL reset_push_addr: got %h expected 3ff", bus0.push_addr); end
   endtask

   task automatic test_push_pop();
      logic [9:0] exp_addr [3] = '{10'h3FF, 10'h3FE, 10'h3FD};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive0(1'b0, 1'b1, 1'b0, 10'h000);
         tests_run++;
         if (bus0.push_addr !== exp_addr[i]) begin tests_failed++; $display("FAIL push_addr_%0d: got %h expected %h", i, bus0.push_addr, exp_addr[i]); end
         tick();
      end
      tests_run++;
      if (bus0.sp !== 10'h3FC) begin tests_failed++; $display("FAIL push3_sp: got %h expected 3fc", bus0.sp); end
      drive0(1'b0, 1'b0, 1'b1, 10'h000);
      tests_run++;
      if (bus0.pop_addr !== 10'h3FD) begin tests_failed++; $display("FAIL pop_addr: got %h expected 3fd", bus0.pop_addr); end
      tick();
      drive0(1'b0, 1'b0, 1'b0, 10'h000);
      tests_run++;
      if (bus0.sp !== 10'h3FD) begin tests_failed++; $display("FAIL pop_sp: got %h expected 3fd", bus0.sp); end
   endtask

   task automatic test_bottom();
      do_reset();
      drive0(1'b1, 1'b0, 1'b0, 10'h001); tick();
      drive0(1'b0, 1'b1, 1'b0, 10'h000); tick();
      tests_run++;
      if ({bus0.sp, bus0.full} !== {10'h000, 1'b0}) begin tests_failed++; $display("FAIL bottom_push1: got sp=%h full=%b expected sp=000 full=0", bus0.sp, bus0.full); end
      tick();
      tests_run++;
      if ({bus0.sp, bus0.full, bus0.empty} !== {10'h000, 1'b1, 1'b0}) begin tests_failed++; $display("FAIL bottom_full: got sp=%h full=%b empty=%b expected sp=000 full=1 empty=0", bus0.sp, bus0.full, bus0.empty); end
      tick();
      tests_run++;
      if ({bus0.sp, bus0.full, errs0()} !== {10'h000, 1'b1, 4'b1000}) begin tests_failed++; $display("FAIL overflow: got sp=%h full=%b errs=%b expected sp=000 full=1 errs=1000", bus0.sp, bus0.full, errs0()); end
      drive0(1'b0, 1'b0, 1'b1, 10'h000);
      tests_run++;
      if (bus0.pop_addr !== 10'h000) begin tests_failed++; $display("FAIL pop_full_addr: got %h expected 000", bus0.pop_addr); end
      tick();
      tests_run++;
      if ({bus0.sp, bus0.full} !== {10'h000, 1'b0}) begin tests_failed++; $display("FAIL pop_full_state: got sp=%h full=%b expected sp=000 full=0", bus0.sp, bus0.full); end
      tests_run++;
      if (bus0.pop_addr !== 10'h001) begin tests_failed++; $display("FAIL pop_bottom_addr: got %h expected 001", bus0.pop_addr); end
      tick();
      drive0(1'b0, 1'b0, 1'b0, 10'h000);
      tests_run++;
      if ({bus0.sp, errs0()} !== {10'h001, 4'b1000}) begin tests_failed++; $display("FAIL pop_bottom_sp: got sp=%h errs=%b expected sp=001 errs=1000", bus0.sp, errs0()); end
   endtask

   task automatic test_underflow();
      do_reset();
      drive0(1'b0, 1'b0, 1'b1, 10'h000); tick();
      tests_run++;
      if ({bus0.sp, errs0()} !== {10'h3FF, 4'b0100}) begin tests_failed++; $display("FAIL underflow: got sp=%h errs=%b expected sp=3ff errs=0100", bus0.sp, errs0()); end
      drive0(1'b0, 1'b1, 1'b0, 10'h000); tick();
      drive0(1'b0, 1'b0, 1'b0, 10'h000);
      tests_run++;
      if ({bus0.sp, errs0()} !== {10'h3FE, 4'b0100}) begin tests_failed++; $display("FAIL underflow_sticky: got sp=%h errs=%b expected sp=3fe errs=0100", bus0.sp, errs0()); end
   endtask

   task automatic test_conflict_load();
      do_reset();
      drive0(1'b1, 1'b0, 1'b0, 10'h3F0); tick();
      drive0(1'b0, 1'b1, 1'b1, 10'h000); tick();
      tests_run++;
      if ({bus0.sp, errs0()} !== {10'h3F0, 4'b0010}) begin tests_failed++; $display("FAIL conflict: got sp=%h errs=%b expected sp=3f0 errs=0010", bus0.sp, errs0()); end
      drive0(1'b1, 1'b1, 1'b0, 10'h200); tick();
      drive0(1'b0, 1'b0, 1'b0, 10'h000);
      tests_run++;
      if ({bus0.sp, bus0.full, errs0()} !== {10'h200, 1'b0, 4'b0010}) begin tests_failed++; $display("FAIL load_over_push: got sp=%h full=%b errs=%b expected sp=200 full=0 errs=0010", bus0.sp, bus0.full, errs0()); end
   endtask

   task automatic test_param_bottom();
      do_reset();
      drive1(1'b1, 1'b0, 1'b0, 10'h0FF); tick();
      tests_run++;
      if ({bus1.sp, errs1()} !== {10'h3FF, 4'b0001}) begin tests_failed++; $display("FAIL range_low: got sp=%h errs=%b expected sp=3ff errs=0001", bus1.sp, errs1()); end
      drive1(1'b1, 1'b0, 1'b0, 10'h100); tick();
      drive1(1'b0, 1'b1, 1'b0, 10'h000); tick();
      tests_run++;
      if ({bus1.sp, bus1.full} !== {10'h100, 1'b1}) begin tests_failed++; $display("FAIL param_full: got sp=%h full=%b expected sp=100 full=1", bus1.sp, bus1.full); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive1(1'b0, 1'b0, 1'b0, 10'h000);
      tests_run++;
      if ({bus1.sp, bus1.full, errs1()} !== {10'h3FF, 1'b0, 4'b0000}) begin tests_failed++; $display("FAIL reset_over_push: got sp=%h full=%b errs=%b expected sp=3ff full=0 errs=0000", bus1.sp, bus1.full, errs1()); end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      drive0(1'b0, 1'b0, 1'b0, 10'h000);
      drive1(1'b0, 1'b0, 1'b0, 10'h000);
      tick();
      test_reset();
      test_push_pop();
      test_bottom();
      test_underflow();
      test_conflict_load();
      test_param_bottom();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
